// File: rtl/dds_wave_gen.sv
// rtl/dds_wave_gen.sv - phase-accumulator DDS core producing sine/square/triangle/sawtooth DAC samples
//
// Ports:
//   sys_clk   in   1   block clock
//   sys_rst   in   1   asynchronous active-high reset
//   wave_sel  in   4   one-hot select: 1000 sine, 0100 square, 0010 triangle, 0001 sawtooth
//   rom_addr  out 12   registered address to external synchronous sine ROM
//   rom_data  in   8   sine ROM output, valid one cycle after rom_addr
//   dac_data  out  8   registered unsigned sample, midscale 128
//   dac_valid out  1   high while dac_data carries a real sample
module dds_wave_gen #(
    parameter logic [31:0] FREQ_CTRL  = 32'd42949,
    parameter logic [11:0] PHASE_CTRL = 12'd0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  wave_sel,
    output logic [11:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [7:0]  dac_data,
    output logic        dac_valid
);

    localparam logic [7:0] MIDSCALE = 8'd128;

    logic [31:0] acc;
    logic [3:0]  sel_reg;
    logic [11:0] addr_d1;
    logic [1:0]  v;
    logic        restart;
    logic [7:0]  tri_ramp;
    logic [7:0]  wave_sample;

    // Any change of selection restarts the phase so the new waveform begins at PHASE_CTRL.
    assign restart  = (wave_sel != sel_reg);
    assign tri_ramp = addr_d1[10:3];

    // addr_d1 lines up with rom_data, so every waveform is computed from the same phase.
    always_comb begin
        wave_sample = MIDSCALE;
        case (sel_reg)
            4'b1000: wave_sample = rom_data;
            4'b0100: wave_sample = addr_d1[11] ? 8'd0 : 8'd255;
            4'b0010: wave_sample = addr_d1[11] ? ~tri_ramp : tri_ramp;
            4'b0001: wave_sample = addr_d1[11:4];
            default: wave_sample = MIDSCALE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            acc       <= 32'd0;
            sel_reg   <= 4'b1000;
            rom_addr  <= 12'd0;
            addr_d1   <= 12'd0;
            v         <= 2'b00;
            dac_valid <= 1'b0;
            dac_data  <= MIDSCALE;
        end else begin
            // The address pipeline keeps running through a restart; its contents are
            // masked by v until the refill from acc = 0 reaches the output.
            rom_addr <= acc[31:20] + PHASE_CTRL;
            addr_d1  <= rom_addr;
            if (restart) begin
                acc       <= 32'd0;
                sel_reg   <= wave_sel;
                v         <= 2'b00;
                dac_valid <= 1'b0;
                dac_data  <= MIDSCALE;
            end else begin
                acc       <= acc + FREQ_CTRL;
                v         <= {v[0], 1'b1};
                dac_valid <= v[1];
                dac_data  <= v[1] ? wave_sample : MIDSCALE;
            end
        end
    end

endmodule

// File: tb/tb_dds_wave_gen.sv
// tb/tb_dds_wave_gen.sv - self-checking bench for dds_wave_gen
module tb_dds_wave_gen;

    logic        clk;
    logic        rst;
    logic [3:0]  wave_sel;
    logic [11:0] rom_addr0, rom_addr1;
    logic [7:0]  rom_data0, rom_data1;
    logic [7:0]  dac_data0, dac_data1;
    logic        dac_valid0, dac_valid1;

    int checks = 0;
    int errors = 0;

    dds_wave_gen #(.FREQ_CTRL(32'h0010_0000), .PHASE_CTRL(12'd0)) dut0 (
        .sys_clk(clk), .sys_rst(rst), .wave_sel(wave_sel),
        .rom_addr(rom_addr0), .rom_data(rom_data0),
        .dac_data(dac_data0), .dac_valid(dac_valid0)
    );

    dds_wave_gen #(.FREQ_CTRL(32'h0010_0000), .PHASE_CTRL(12'd1024)) dut1 (
        .sys_clk(clk), .sys_rst(rst), .wave_sel(wave_sel),
        .rom_addr(rom_addr1), .rom_data(rom_data1),
        .dac_data(dac_data1), .dac_valid(dac_valid1)
    );

    // ROM model: ROM[i] = i[7:0], one cycle read latency
    always @(posedge clk) begin
        rom_data0 <= rom_addr0[7:0];
        rom_data1 <= rom_addr1[7:0];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected sample for a phase address, straight from the waveform definitions
    function automatic logic [7:0] exp_wave(input logic [3:0] sel, input int addr);
        logic [11:0] a;
        a = addr[11:0];
        case (sel)
            4'b1000: exp_wave = a[7:0];
            4'b0100: exp_wave = (addr < 2048) ? 8'd255 : 8'd0;
            4'b0010: exp_wave = (addr < 2048) ? a[10:3] : 8'(255 - a[10:3]);
            4'b0001: exp_wave = 8'(addr / 16);
            default: exp_wave = 8'd128;
        endcase
    endfunction

    typedef struct {
        logic [3:0]  sel;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic        chk_addr;
        logic [11:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] s, input logic ev, input logic [7:0] ed,
                                input logic ca, input logic [11:0] ea);
        vec_t t;
        t.sel = s; t.exp_valid = ev; t.exp_data = ed; t.chk_addr = ca; t.exp_addr = ea;
        return t;
    endfunction

    logic [3:0] sweep_sel [4];

    initial begin
        // sine startup after reset release, ROM[i] = i
        vecs.push_back(mk(4'b1000, 1'b0, 8'd128, 1'b1, 12'd0));
        vecs.push_back(mk(4'b1000, 1'b0, 8'd128, 1'b1, 12'd1));
        vecs.push_back(mk(4'b1000, 1'b1, 8'd0,   1'b1, 12'd2));
        vecs.push_back(mk(4'b1000, 1'b1, 8'd1,   1'b0, 12'd0));
        vecs.push_back(mk(4'b1000, 1'b1, 8'd2,   1'b0, 12'd0));
        // sine -> square mid-stream
        vecs.push_back(mk(4'b0100, 1'b0, 8'd128, 1'b0, 12'd0));
        vecs.push_back(mk(4'b0100, 1'b0, 8'd128, 1'b1, 12'd0));
        vecs.push_back(mk(4'b0100, 1'b0, 8'd128, 1'b0, 12'd0));
        vecs.push_back(mk(4'b0100, 1'b1, 8'd255, 1'b0, 12'd0));
        vecs.push_back(mk(4'b0100, 1'b1, 8'd255, 1'b0, 12'd0));
        // back-to-back changes: triangle then sawtooth
        vecs.push_back(mk(4'b0010, 1'b0, 8'd128, 1'b0, 12'd0));
        vecs.push_back(mk(4'b0001, 1'b0, 8'd128, 1'b0, 12'd0));
        vecs.push_back(mk(4'b0001, 1'b0, 8'd128, 1'b0, 12'd0));
        vecs.push_back(mk(4'b0001, 1'b0, 8'd128, 1'b0, 12'd0));
        vecs.push_back(mk(4'b0001, 1'b1, 8'd0,   1'b0, 12'd0));
        // one-cycle glitch to square and back: two restarts
        vecs.push_back(mk(4'b0100, 1'b0, 8'd128, 1'b0, 12'd0));
        vecs.push_back(mk(4'b0001, 1'b0, 8'd128, 1'b0, 12'd0));
        vecs.push_back(mk(4'b0001, 1'b0, 8'd128, 1'b0, 12'd0));
        vecs.push_back(mk(4'b0001, 1'b0, 8'd128, 1'b0, 12'd0));
        vecs.push_back(mk(4'b0001, 1'b1, 8'd0,   1'b0, 12'd0));
        // invalid select: valid after refill, data pinned at midscale
        vecs.push_back(mk(4'b0110, 1'b0, 8'd128, 1'b0, 12'd0));
        vecs.push_back(mk(4'b0110, 1'b0, 8'd128, 1'b0, 12'd0));
        vecs.push_back(mk(4'b0110, 1'b0, 8'd128, 1'b0, 12'd0));
        vecs.push_back(mk(4'b0110, 1'b1, 8'd128, 1'b0, 12'd0));
        vecs.push_back(mk(4'b0110, 1'b1, 8'd128, 1'b0, 12'd0));

        sweep_sel[0] = 4'b0001;
        sweep_sel[1] = 4'b0010;
        sweep_sel[2] = 4'b0100;
        sweep_sel[3] = 4'b1000;

        // reset state
        rst = 1'b1;
        wave_sel = 4'b1000;
        #1;
        chk("rst_valid0", 32'(dac_valid0), 32'd0);
        chk("rst_data0", 32'(dac_data0), 32'd128);
        chk("rst_addr0", 32'(rom_addr0), 32'd0);
        chk("rst_addr1", 32'(rom_addr1), 32'd0);
        step();
        step();
        chk("rst_hold_valid1", 32'(dac_valid1), 32'd0);
        chk("rst_hold_data1", 32'(dac_data1), 32'd128);
        rst = 1'b0;

        // first phase-offset address from the PHASE_CTRL=1024 instance
        for (int i = 0; i < vecs.size(); i++) begin
            wave_sel = vecs[i].sel;
            step();
            chk($sformatf("vec%0d_valid", i), 32'(dac_valid0), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_data", i), 32'(dac_data0), 32'(vecs[i].exp_data));
            if (vecs[i].chk_addr)
                chk($sformatf("vec%0d_addr", i), 32'(rom_addr0), 32'(vecs[i].exp_addr));
            if (i == 0)
                chk("phase1_addr_e1", 32'(rom_addr1), 32'd1024);
        end

        // full-period sweeps; edge k counts from the restart edge, sample at k uses
        // address PHASE + (k-3) since the increment is one address per clock
        for (int s = 0; s < 4; s++) begin
            wave_sel = sweep_sel[s];
            for (int k = 0; k <= 4100; k++) begin
                logic [7:0] e0, e1;
                logic       ev;
                step();
                ev = (k >= 3);
                e0 = ev ? exp_wave(sweep_sel[s], (k - 3) % 4096) : 8'd128;
                e1 = ev ? exp_wave(sweep_sel[s], (1024 + k - 3) % 4096) : 8'd128;
                if (dac_valid0 !== ev || dac_data0 !== e0) begin
                    chk($sformatf("sweep%0d_k%0d_valid0", s, k), 32'(dac_valid0), 32'(ev));
                    chk($sformatf("sweep%0d_k%0d_data0", s, k), 32'(dac_data0), 32'(e0));
                end else begin
                    checks++;
                end
                if (dac_valid1 !== ev || dac_data1 !== e1) begin
                    chk($sformatf("sweep%0d_k%0d_valid1", s, k), 32'(dac_valid1), 32'(ev));
                    chk($sformatf("sweep%0d_k%0d_data1", s, k), 32'(dac_data1), 32'(e1));
                end else begin
                    checks++;
                end
                if (sweep_sel[s] == 4'b0100 && k == 3)
                    chk("square_phase1024_first", 32'(dac_data1), 32'd255);
                if (sweep_sel[s] == 4'b0100 && k == 3 + 1024)
                    chk("square_phase1024_fall", 32'(dac_data1), 32'd0);
                if (sweep_sel[s] == 4'b0001 && k == 3 + 4096)
                    chk("saw_wrap_zero", 32'(dac_data0), 32'd0);
                if (sweep_sel[s] == 4'b0010 && k == 3 + 2048)
                    chk("tri_peak", 32'(dac_data0), 32'd255);
            end
        end

        // asynchronous reset mid-stream (sine still running)
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid0", 32'(dac_valid0), 32'd0);
        chk("async_rst_data0", 32'(dac_data0), 32'd128);
        chk("async_rst_addr0", 32'(rom_addr0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("refill_e1_valid", 32'(dac_valid0), 32'd0);
        step();
        chk("refill_e2_valid", 32'(dac_valid0), 32'd0);
        step();
        chk("refill_e3_valid", 32'(dac_valid0), 32'd1);
        chk("refill_e3_data", 32'(dac_data0), 32'd0);
        chk("refill_e3_data1", 32'(dac_data1), 32'd0);
        step();
        chk("refill_e4_data", 32'(dac_data0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/dds_wave_gen.md
# dds_wave_gen

Phase-accumulator DDS core directly downstream of the key-debounce/waveform-select stage. It consumes the one-hot `wave_sel` code and produces an 8-bit unsigned DAC sample stream every clock. Sine comes from an external synchronous 4096×8 ROM. Square, triangle and sawtooth are computed from the phase address. The block restarts the phase cleanly at 0 whenever the selection changes, so every new waveform starts glitch-free.

## Interface
- `FREQ_CTRL`, default 32'd42949: phase increment per clock; f_out = f_clk·FREQ_CTRL/2^32, which gives ≈500 Hz at 50 MHz.
- `PHASE_CTRL`, default 12'd0: constant phase offset, added to the ROM/phase address.
- `sys_clk`, in, 1: single clock for the block.
- `sys_rst`, in, 1: asynchronous, active-high reset.
- `wave_sel`, in, 4: one-hot waveform select.
  - 4'b1000: sine.
  - 4'b0100: square.
  - 4'b0010: triangle.
  - 4'b0001: sawtooth.
- `rom_addr`, out, 12: registered address to the external sine ROM.
- `rom_data`, in, 8: sine ROM output, registered in the ROM, valid 1 cycle after `rom_addr`.
- `dac_data`, out, 8: registered unsigned sample, midscale = 8'd128.
- `dac_valid`, out, 1: high while `dac_data` carries a real sample.

## Operation
- Internal registers:
  - `acc`: 32-bit phase accumulator.
  - `sel_reg`: 4-bit registered selection.
  - `addr_d1`: 12-bit copy of `rom_addr`.
  - `v`: 2-bit valid shift chain feeding `dac_valid`.
- Restart condition: `wave_sel != sel_reg` at a clock edge. On that edge:
  - `acc` ← 0.
  - `sel_reg` ← `wave_sel`.
  - `v` ← 0.
  - `dac_valid` ← 0.
  - `dac_data` ← 128.
  - `rom_addr` and `addr_d1` still update normally; their values are don't-care while invalid.
- Normal edge, with no restart:
  - `acc` ← `acc` + FREQ_CTRL, mod 2^32, silent wrap.
  - `rom_addr` ← `acc[31:20]` + PHASE_CTRL, mod 4096.
  - `addr_d1` ← `rom_addr`.
  - `v` ← {`v[0]`, 1}.
  - `dac_valid` ← `v[1]`.
- Output mux on a normal edge, with `a` = `addr_d1` (all widths 8-bit unsigned):
  - `dac_data` ← 128 if `v[1]` = 0.
  - Otherwise, by `sel_reg`:
    - Sine: `rom_data`.
    - Square: `a[11]` = 0 → 255, else 0.
    - Triangle: `a[11]` = 0 → `a[10:3]`, else ~`a[10:3]` (rises 0→255, falls 255→0).
    - Sawtooth: `a[11:4]`.
  - `sel_reg` not one-hot (including 4'b0000): 128, with `dac_valid` still following `v`.
- `rom_data` is consumed only when `sel_reg` = 4'b1000, but `rom_addr` always advances.
- Reset values:
  - `acc` = 0.
  - `sel_reg` = 4'b1000, matching the upstream reset value so no restart occurs after reset.
  - `rom_addr` = 0.
  - `addr_d1` = 0.
  - `v` = 0.
  - `dac_valid` = 0.
  - `dac_data` = 8'd128.
- Reset mid-stream: all state returns to the reset values immediately (asynchronous). The pipeline then refills exactly as after a restart.

## Timing
- Reset release or restart edge = edge E0.
  - E1: `rom_addr` = PHASE_CTRL; `acc` = FREQ_CTRL.
  - E2: `addr_d1` = PHASE_CTRL; `rom_data` = ROM[PHASE_CTRL].
  - E3: `dac_data` = wave(PHASE_CTRL); `dac_valid` = 1.
- First valid sample appears 3 clocks after E0 and always corresponds to phase address PHASE_CTRL.
- Steady-state latency is 2 clocks from `rom_addr` to the `dac_data` computed from it, with one sample per clock and no stalls.
- Back-to-back `wave_sel` changes on consecutive edges: each one restarts, and `dac_valid` stays low until 3 edges after the last change.
- A `wave_sel` change of 1 cycle that returns to the old value is a restart on each edge: two restarts.
- 32-bit `acc` wrap and 12-bit address wrap (4095→0) cause no gap in `dac_valid`.

## Test plan
- Reset then release, with `wave_sel` = 4'b1000 and ROM model ROM[i] = i[7:0] → `dac_valid` stays 0 for 2 edges and rises on edge 3. `dac_data` = 128 until then, then 0, 1, 2, … when FREQ_CTRL = 32'h0010_0000.
- Sawtooth, FREQ_CTRL = 32'h0010_0000, PHASE_CTRL = 0 → `dac_data` increments once every 16 clocks. It goes 255→0 at address wrap, with period 4096 clocks and no `dac_valid` drop.
- Triangle, same FREQ_CTRL → `dac_data` peaks at 255 around address 2047/2048 and returns to 0 at 4095/0, with each value held 8 clocks.
- Square, PHASE_CTRL = 12'd1024 → first valid sample = 255. `dac_data` falls to 0 1024 clocks after `dac_valid` rises, with a 50% duty cycle.
- Switch from sine to square mid-stream at edge E0 → `dac_valid` = 0 and `dac_data` = 128 on E0..E2. Valid square sample = 255 on E3.
- Invalid `wave_sel` = 4'b0110 → restart, then `dac_valid` = 1 after 3 edges with `dac_data` fixed at 128. Asserting `sys_rst` mid-stream asynchronously forces `dac_valid` = 0 and `dac_data` = 128.
